// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-side control slice.
//   pc_state_t         : run/step/halt controller state encoding (3 bits)
//   PC_INC_DEFAULT     : default sequential PC increment in bytes
//   PIPE_DEPTH_DEFAULT : default drain length after a halt
//   HALT_OPCODE        : opcode the decoder recognises as a halt
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } pc_state_t;

  localparam int PC_INC_DEFAULT     = 4;
  localparam int PIPE_DEPTH_DEFAULT = 4;
  localparam logic [5:0] HALT_OPCODE = 6'h3f;

endpackage

// File: rtl/next_pc_unit_if.sv
// Bundle between next_pc_unit and its neighbours (PC register, hazard unit,
// decoder, debug unit).
//   master : next_pc_unit side (drives PC_NEXT/PC_CTRL/ENABLE/FLUSH_IF,
//            HALTED/STEP_ACK/CYCLE_COUNT and the STATE debug view)
//   slave  : environment side (drives PC_CUR, hazard, redirect, halt and
//            debug commands)
// Handshake semantics: PC_CTRL/ENABLE act as the valid for PC_NEXT; the PC
// register accepts PC_NEXT on every rising clock edge where ENABLE is high.
// DBG_START and DBG_STEP are single-cycle pulses with no ready; a pulse that
// arrives when the controller cannot use it is dropped, not queued.
interface next_pc_unit_if
  import mips_pkg::*;
#(
  parameter int W = 32
);
  logic [W-1:0] PC_CUR;
  logic         STALL;
  logic         BRANCH_TAKEN;
  logic [W-1:0] BRANCH_TARGET;
  logic         JUMP;
  logic [W-1:0] JUMP_TARGET;
  logic         HALT_DETECTED;
  logic         DBG_MODE;
  logic         DBG_START;
  logic         DBG_STEP;
  logic [W-1:0] PC_NEXT;
  logic         PC_CTRL;
  logic         ENABLE;
  logic         FLUSH_IF;
  logic         HALTED;
  logic         STEP_ACK;
  logic [31:0]  CYCLE_COUNT;
  pc_state_t    STATE;

  modport master (
    input  PC_CUR, STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET,
           HALT_DETECTED, DBG_MODE, DBG_START, DBG_STEP,
    output PC_NEXT, PC_CTRL, ENABLE, FLUSH_IF, HALTED, STEP_ACK,
           CYCLE_COUNT, STATE
  );

  modport slave (
    output PC_CUR, STALL, BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET,
           HALT_DETECTED, DBG_MODE, DBG_START, DBG_STEP,
    input  PC_NEXT, PC_CTRL, ENABLE, FLUSH_IF, HALTED, STEP_ACK,
           CYCLE_COUNT, STATE
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   CLK, RESET : clock, asynchronous active-high reset (count -> 0)
//   CLR        : synchronous clear, wins over INC
//   INC        : count up by one, holding at all-ones
//   COUNT      : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COUNT <= '0;
    end else if (CLR) begin
      COUNT <= '0;
    end else if (INC && (COUNT != '1)) begin
      COUNT <= COUNT + W'(1);
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-side next-PC controller.
//   CLK, RESET : clock, asynchronous active-high reset
//   pc         : next_pc_unit_if.master bundle
//     PC_NEXT  : branch target > jump target > PC_CUR + PC_INC (mod 2^W)
//     ENABLE / PC_CTRL : PC write enable, only while advancing
//     FLUSH_IF : redirect accepted this cycle, kill the IF instruction
//     HALTED   : sticky, set once the pipeline has drained after a halt
//     STEP_ACK : one-cycle pulse after a single step retires its PC write
//     CYCLE_COUNT : saturating count of RUN/STEP_EXEC/DRAIN cycles
//     STATE    : controller state, for observation
module next_pc_unit
  import mips_pkg::*;
#(
  parameter int W          = 32,
  parameter int PC_INC     = PC_INC_DEFAULT,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          RESET,
  next_pc_unit_if.master pc
);

  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  pc_state_t     state, state_next;
  logic [DW-1:0] drain_cnt;
  logic          advance;
  logic          eff_halt;
  logic          enable;
  logic          halted_q;
  logic          step_ack_q;
  logic          cnt_clr;
  logic          cnt_inc;

  // A halt decoded alongside a taken branch sits on the flushed path.
  assign eff_halt = pc.HALT_DETECTED & ~pc.BRANCH_TAKEN;
  assign advance  = (state == S_RUN) || (state == S_STEP_EXEC);
  assign enable   = advance & ~pc.STALL & ~eff_halt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (pc.DBG_START) state_next = pc.DBG_MODE ? S_STEP_WAIT : S_RUN;
      S_RUN:       if (eff_halt) state_next = S_DRAIN;
      S_STEP_WAIT: if (pc.DBG_STEP) state_next = S_STEP_EXEC;
      S_STEP_EXEC: begin
        if (eff_halt)       state_next = S_DRAIN;
        else if (!pc.STALL) state_next = S_STEP_WAIT;
      end
      S_DRAIN:     if (drain_cnt == '0) state_next = S_HALTED;
      S_HALTED:    state_next = S_HALTED;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc.PC_NEXT = pc.PC_CUR + W'(PC_INC);
    if (pc.BRANCH_TAKEN)  pc.PC_NEXT = pc.BRANCH_TARGET;
    else if (pc.JUMP)     pc.PC_NEXT = pc.JUMP_TARGET;
  end

  assign pc.ENABLE   = enable;
  assign pc.PC_CTRL  = enable;
  assign pc.FLUSH_IF = enable & (pc.BRANCH_TAKEN | pc.JUMP);
  assign pc.HALTED   = halted_q;
  assign pc.STEP_ACK = step_ack_q;
  assign pc.STATE    = state;

  // Drain counter is loaded on the edge that enters DRAIN, so DRAIN lasts
  // exactly PIPE_DEPTH cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drain_cnt  <= '0;
      halted_q   <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      if (advance && eff_halt) begin
        drain_cnt <= DW'(PIPE_DEPTH - 1);
      end else if (state == S_DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
      halted_q   <= (state_next == S_HALTED);
      step_ack_q <= (state == S_STEP_EXEC) && (state_next == S_STEP_WAIT);
    end
  end

  assign cnt_clr = (state == S_IDLE) && pc.DBG_START;
  assign cnt_inc = advance || (state == S_DRAIN);

  sat_counter #(.W(32)) u_cycle_count (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (cnt_clr),
    .INC   (cnt_inc),
    .COUNT (pc.CYCLE_COUNT)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;
  import mips_pkg::*;

  localparam int W  = 32;
  localparam int PD = 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  next_pc_unit_if #(.W(W)) pif ();

  next_pc_unit #(.W(W), .PC_INC(4), .PIPE_DEPTH(PD)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .pc    (pif)
  );

  logic       sc_clr = 1'b0;
  logic       sc_inc = 1'b0;
  logic [3:0] sc_count;

  sat_counter #(.W(4)) u_sc (
    .CLK   (CLK),
    .RESET (RESET),
    .CLR   (sc_clr),
    .INC   (sc_inc),
    .COUNT (sc_count)
  );

  // ---------------- stimulus values ----------------
  logic        s_stall, s_br, s_jmp, s_halt, s_mode, s_start, s_step;
  logic [31:0] s_bt, s_jt;

  // ---------------- reference model ----------------
  bit          m_started, m_step_mode, m_exec, m_halted, m_ack;
  int          m_drain;
  logic [31:0] m_cnt;
  logic [31:0] m_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_acks, obs_writes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    s_stall = 0; s_br = 0; s_jmp = 0; s_halt = 0;
    s_mode = 0; s_start = 0; s_step = 0;
    s_bt = '0; s_jt = '0;
  endtask

  task automatic model_reset();
    m_started = 0; m_step_mode = 0; m_exec = 0; m_halted = 0; m_ack = 0;
    m_drain = 0; m_cnt = '0;
  endtask

  task automatic drive();
    pif.PC_CUR        = m_pc;
    pif.STALL         = s_stall;
    pif.BRANCH_TAKEN  = s_br;
    pif.BRANCH_TARGET = s_bt;
    pif.JUMP          = s_jmp;
    pif.JUMP_TARGET   = s_jt;
    pif.HALT_DETECTED = s_halt;
    pif.DBG_MODE      = s_mode;
    pif.DBG_START     = s_start;
    pif.DBG_STEP      = s_step;
  endtask

  // One clock cycle: drive at negedge, check just after, advance the model
  // to what the following rising edge should do.
  task automatic tick(input string tag);
    bit          adv, eff, e_en, e_flush, new_ack;
    logic [31:0] e_next;
    longint      sum;
    @(negedge CLK);
    drive();
    #1;
    adv = m_started && !m_halted && (m_drain == 0) && (!m_step_mode || m_exec);
    eff = s_halt && !s_br;
    sum = longint'(m_pc) + 4;
    e_next = s_br ? s_bt : (s_jmp ? s_jt : 32'(sum % 64'h1_0000_0000));
    e_en = adv && !s_stall && !eff;
    e_flush = e_en && (s_br || s_jmp);
    chk({tag, ".pc_next"}, pif.PC_NEXT, e_next);
    chk({tag, ".enable"}, pif.ENABLE, e_en);
    chk({tag, ".pc_ctrl"}, pif.PC_CTRL, e_en);
    chk({tag, ".flush_if"}, pif.FLUSH_IF, e_flush);
    chk({tag, ".halted"}, pif.HALTED, m_halted);
    chk({tag, ".step_ack"}, pif.STEP_ACK, m_ack);
    chk({tag, ".cycle_count"}, pif.CYCLE_COUNT, m_cnt);
    if (pif.STEP_ACK) obs_acks++;
    if (pif.ENABLE) obs_writes++;
    new_ack = 0;
    if (!m_started) begin
      if (s_start) begin
        m_started = 1; m_step_mode = s_mode; m_exec = 0; m_cnt = '0;
      end
    end else if (m_halted) begin
      // only reset leaves the halted condition
    end else if (m_drain > 0) begin
      if (m_cnt != 32'hffff_ffff) m_cnt++;
      m_drain--;
      if (m_drain == 0) m_halted = 1;
    end else if (adv) begin
      if (m_cnt != 32'hffff_ffff) m_cnt++;
      if (eff) m_drain = PD;
      else if (m_step_mode && !s_stall) begin
        m_exec = 0;
        new_ack = 1;
      end
    end else if (s_step) begin
      m_exec = 1;
    end
    m_ack = new_ack;
    if (e_en) m_pc = e_next;
    s_start = 0; s_step = 0; s_halt = 0;
  endtask

  // Reset asserted between edges; outputs must fall back immediately.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    clr_in();
    m_pc = '0;
    drive();
    RESET = 1'b1;
    #1;
    model_reset();
    chk({tag, ".enable"}, pif.ENABLE, 0);
    chk({tag, ".pc_ctrl"}, pif.PC_CTRL, 0);
    chk({tag, ".flush_if"}, pif.FLUSH_IF, 0);
    chk({tag, ".halted"}, pif.HALTED, 0);
    chk({tag, ".step_ack"}, pif.STEP_ACK, 0);
    chk({tag, ".cycle_count"}, pif.CYCLE_COUNT, 0);
    chk({tag, ".pc_next"}, pif.PC_NEXT, 32'd4);
    chk({tag, ".state"}, pif.STATE, 0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
  endtask

  task automatic rand_redirect();
    s_br  = ($urandom_range(0, 5) == 0);
    s_jmp = ($urandom_range(0, 5) == 0);
    s_bt  = $urandom & 32'hffff_fffc;
    s_jt  = $urandom & 32'hffff_fffc;
  endtask

  logic [3:0] sc_exp;

  initial begin
    clr_in();
    m_pc = '0;
    model_reset();
    drive();

    // ---- reset, then continuous run from PC 0 ----
    do_reset("rst0");
    s_start = 1; s_mode = 0;
    tick("start_run");
    s_mode = 0;
    for (int i = 0; i < 8; i++) tick("seq");

    // ---- randomized run with redirects and stalls ----
    for (int i = 0; i < 40; i++) begin
      rand_redirect();
      s_stall = ($urandom_range(0, 3) == 0);
      tick("rand_run");
    end
    clr_in();

    // ---- branch and jump together: branch wins ----
    s_br = 1; s_bt = 32'h40; s_jmp = 1; s_jt = 32'h80;
    tick("br_jmp");
    s_br = 1; s_bt = 32'h40; s_jmp = 1; s_jt = 32'h80; s_stall = 1;
    tick("br_jmp_stall");
    clr_in();

    // ---- wrap-around of sequential PC ----
    m_pc = 32'hffff_fffc;
    tick("wrap");
    tick("after_wrap");

    // ---- halt coincident with taken branch is ignored ----
    s_halt = 1; s_br = 1; s_bt = 32'h100;
    tick("halt_br");
    clr_in();
    tick("post_halt_br");

    // ---- real halt at PC 0x20, drain, then ignore debug commands ----
    m_pc = 32'h20;
    tick("pre_halt");
    s_halt = 1;
    tick("halt");
    for (int i = 0; i < PD + 1; i++) tick("drain");
    s_start = 1; tick("halted_start");
    s_step = 1;  tick("halted_step");
    tick("halted_hold");

    // ---- reset mid-drain, then restart in step mode ----
    do_reset("rst1");
    s_start = 1; tick("restart_run");
    tick("run1");
    s_halt = 1; tick("halt2");
    tick("drain2");
    do_reset("rst_drain");

    s_start = 1; s_mode = 1;
    tick("start_step");
    s_mode = 0;
    obs_acks = 0; obs_writes = 0;
    s_step = 1; tick("step1");
    tick("exec1");
    for (int i = 0; i < 2; i++) tick("idle1");
    s_step = 1; tick("step2");
    s_stall = 1; tick("exec2_stall");
    s_stall = 1; tick("exec2_stall");
    s_stall = 0; tick("exec2");
    tick("ack2");
    s_step = 1; tick("step3");
    s_step = 1; tick("step3_dup");
    for (int i = 0; i < 3; i++) tick("tail3");
    chk("step_writes", obs_writes, 3);
    chk("step_acks", obs_acks, 3);

    // ---- randomized step traffic ----
    for (int i = 0; i < 60; i++) begin
      rand_redirect();
      s_stall = ($urandom_range(0, 3) == 0);
      s_step  = ($urandom_range(0, 2) == 0);
      s_start = ($urandom_range(0, 9) == 0);
      tick("rand_step");
    end
    clr_in();
    s_halt = 1; tick("step_halt_wait");
    s_step = 1; tick("step_for_halt");
    s_halt = 1; tick("step_halt_exec");
    for (int i = 0; i < PD + 2; i++) tick("step_drain");

    // ---- saturation of the counter, shown on a 4-bit instance ----
    do_reset("rst2");
    sc_exp = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      sc_inc = 1'b1;
      #1;
      chk("sat4", 32'(sc_count), 32'(sc_exp));
      if (sc_exp != 4'hf) sc_exp++;
    end
    @(negedge CLK);
    sc_clr = 1'b1;
    #1;
    chk("sat4_pre_clr", 32'(sc_count), 32'(sc_exp));
    sc_exp = '0;
    @(negedge CLK);
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    #1;
    chk("sat4_clr", 32'(sc_count), 32'(sc_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
